// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage results in, register-file write port and retire count out.
interface mem_wb_stage_if #(
    parameter int CNT_W = 32
);
    logic              Stall_i;
    logic              Flush_i;
    logic              Valid_i;
    logic              RegWrite_i;
    logic [4:0]        WriteReg_i;
    logic [1:0]        MemToReg_i;
    logic [2:0]        LoadType_i;
    logic [1:0]        ByteOffset_i;
    logic [31:0]       ALUResult_i;
    logic [31:0]       MemData_i;
    logic [31:0]       PCPlus4_i;
    logic              Valid_o;
    logic              RegWrite_o;
    logic [4:0]        WriteReg_o;
    logic [31:0]       WriteData_o;
    logic [CNT_W-1:0]  RetireCount_o;

    modport master (
        output Stall_i, Flush_i, Valid_i, RegWrite_i, WriteReg_i, MemToReg_i,
               LoadType_i, ByteOffset_i, ALUResult_i, MemData_i, PCPlus4_i,
        input  Valid_o, RegWrite_o, WriteReg_o, WriteData_o, RetireCount_o
    );

    modport slave (
        input  Stall_i, Flush_i, Valid_i, RegWrite_i, WriteReg_i, MemToReg_i,
               LoadType_i, ByteOffset_i, ALUResult_i, MemData_i, PCPlus4_i,
        output Valid_o, RegWrite_o, WriteReg_o, WriteData_o, RetireCount_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats sub-word loads, selects the write-back source,
// registers the register-file write port and counts retired instructions.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    mem_wb_stage_if.slave bus
);

    // Little-endian lane pick; halves ignore offset bit 0, LW ignores the offset.
    function automatic logic [31:0] formatLoad(input logic [2:0]  loadType,
                                               input logic [1:0]  byteOffset,
                                               input logic [31:0] word);
        logic [7:0]  byteLane;
        logic [15:0] halfLane;
        logic [31:0] result;
        case (byteOffset)
            2'd0:    byteLane = word[7:0];
            2'd1:    byteLane = word[15:8];
            2'd2:    byteLane = word[23:16];
            2'd3:    byteLane = word[31:24];
            default: byteLane = word[7:0];
        endcase
        halfLane = byteOffset[1] ? word[31:16] : word[15:0];
        case (loadType)
            3'b001:  result = {{24{byteLane[7]}}, byteLane};
            3'b010:  result = {24'h000000, byteLane};
            3'b011:  result = {{16{halfLane[15]}}, halfLane};
            3'b100:  result = {16'h0000, halfLane};
            default: result = word;
        endcase
        return result;
    endfunction

    logic [31:0]      writeDataNext;
    logic             regWriteNext;
    logic             validR;
    logic             regWriteR;
    logic [4:0]       writeRegR;
    logic [31:0]      writeDataR;
    logic [CNT_W-1:0] retireCountR;

    // Write-back source select and gated write enable for the next capture.
    always_comb begin
        writeDataNext = bus.ALUResult_i;
        regWriteNext  = bus.RegWrite_i & bus.Valid_i & (bus.WriteReg_i != 5'd0);
        case (bus.MemToReg_i)
            2'b01:   writeDataNext = formatLoad(bus.LoadType_i, bus.ByteOffset_i, bus.MemData_i);
            2'b10:   writeDataNext = bus.PCPlus4_i;
            default: writeDataNext = bus.ALUResult_i;
        endcase
    end

    // Stage register: reset beats flush, flush beats stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            validR       <= 1'b0;
            regWriteR    <= 1'b0;
            writeRegR    <= 5'd0;
            writeDataR   <= 32'h00000000;
            retireCountR <= {CNT_W{1'b0}};
        end else if (bus.Flush_i) begin
            validR       <= 1'b0;
            regWriteR    <= 1'b0;
            writeRegR    <= 5'd0;
            writeDataR   <= 32'h00000000;
        end else if (bus.Stall_i) begin
            validR       <= validR;
            regWriteR    <= regWriteR;
            writeRegR    <= writeRegR;
            writeDataR   <= writeDataR;
        end else begin
            validR       <= bus.Valid_i;
            regWriteR    <= regWriteNext;
            writeRegR    <= bus.WriteReg_i;
            writeDataR   <= writeDataNext;
            if (bus.Valid_i) begin
                retireCountR <= retireCountR + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.Valid_o       = validR;
    assign bus.RegWrite_o    = regWriteR;
    assign bus.WriteReg_o    = writeRegR;
    assign bus.WriteData_o   = writeDataR;
    assign bus.RetireCount_o = retireCountR;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table through a scoreboard queue, plus stall,
// flush, asynchronous reset and 4-bit counter wrap sequences.
module tb_mem_wb_stage;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [1:0]  memToReg;
        logic [2:0]  loadType;
        logic [1:0]  byteOffset;
        logic [31:0] aluResult;
        logic [31:0] memData;
        logic [31:0] pcPlus4;
        logic        expRegWrite;
        logic [31:0] expWriteData;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [31:0] writeData;
        logic [31:0] count;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t expQ[$];
    exp_t model;
    vec_t vecs[$];

    mem_wb_stage_if #(.CNT_W(32)) bus ();
    mem_wb_stage_if #(.CNT_W(4))  busS ();

    mem_wb_stage #(.CNT_W(32)) dut      (.clk_i(clk), .rst_i(rst), .bus(bus));
    mem_wb_stage #(.CNT_W(4))  dutSmall (.clk_i(clk), .rst_i(rst), .bus(busS));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] wr,
                                input logic [1:0] m2r, input logic [2:0] lt, input logic [1:0] off,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                                input logic eRw, input logic [31:0] eWd);
        vec_t t;
        t.stall = 1'b0; t.flush = 1'b0; t.valid = v; t.regWrite = rw; t.writeReg = wr;
        t.memToReg = m2r; t.loadType = lt; t.byteOffset = off; t.aluResult = alu;
        t.memData = mem; t.pcPlus4 = pc4; t.expRegWrite = eRw; t.expWriteData = eWd;
        return t;
    endfunction

    task automatic compareOut(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: actual=empty required=entry", tag);
        end else begin
            e = expQ.pop_front();
            check({tag, " Valid_o"},       {31'd0, bus.Valid_o},    {31'd0, e.valid});
            check({tag, " RegWrite_o"},    {31'd0, bus.RegWrite_o}, {31'd0, e.regWrite});
            check({tag, " WriteReg_o"},    {27'd0, bus.WriteReg_o}, {27'd0, e.writeReg});
            check({tag, " WriteData_o"},   bus.WriteData_o,         e.writeData);
            check({tag, " RetireCount_o"}, bus.RetireCount_o,       e.count);
        end
    endtask

    // Called just after a sample point; drives, predicts, waits one edge, compares.
    task automatic applyVec(input string tag, input vec_t t);
        bus.Stall_i = t.stall; bus.Flush_i = t.flush; bus.Valid_i = t.valid;
        bus.RegWrite_i = t.regWrite; bus.WriteReg_i = t.writeReg; bus.MemToReg_i = t.memToReg;
        bus.LoadType_i = t.loadType; bus.ByteOffset_i = t.byteOffset;
        bus.ALUResult_i = t.aluResult; bus.MemData_i = t.memData; bus.PCPlus4_i = t.pcPlus4;
        if (t.flush) begin
            model.valid = 1'b0; model.regWrite = 1'b0; model.writeReg = 5'd0; model.writeData = 32'h0;
        end else if (!t.stall) begin
            model.valid = t.valid; model.regWrite = t.expRegWrite;
            model.writeReg = t.writeReg; model.writeData = t.expWriteData;
            if (t.valid) model.count = model.count + 32'd1;
        end
        expQ.push_back(model);
        @(posedge clk);
        #1;
        compareOut(tag);
    endtask

    initial begin
        vec_t t;
        logic [31:0] md;
        md = 32'h80FF7F01;
        rst = 1'b1;
        bus.Stall_i = 1'b0; bus.Flush_i = 1'b0; bus.Valid_i = 1'b0; bus.RegWrite_i = 1'b0;
        bus.WriteReg_i = 5'd0; bus.MemToReg_i = 2'b00; bus.LoadType_i = 3'b000;
        bus.ByteOffset_i = 2'b00; bus.ALUResult_i = 32'h0; bus.MemData_i = 32'h0; bus.PCPlus4_i = 32'h0;
        busS.Stall_i = 1'b0; busS.Flush_i = 1'b0; busS.Valid_i = 1'b0; busS.RegWrite_i = 1'b0;
        busS.WriteReg_i = 5'd0; busS.MemToReg_i = 2'b00; busS.LoadType_i = 3'b000;
        busS.ByteOffset_i = 2'b00; busS.ALUResult_i = 32'h0; busS.MemData_i = 32'h0; busS.PCPlus4_i = 32'h0;
        model = '{valid: 1'b0, regWrite: 1'b0, writeReg: 5'd0, writeData: 32'h0, count: 32'h0};

        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.push_back(model);
        compareOut("reset");

        vecs.push_back(mk(1'b1, 1'b1, 5'd5,  2'b00, 3'b000, 2'd0, 32'h00001234, md, 32'h0, 1'b1, 32'h00001234));
        vecs.push_back(mk(1'b1, 1'b1, 5'd6,  2'b01, 3'b001, 2'd3, 32'h0, md, 32'h0, 1'b1, 32'hFFFFFF80));
        vecs.push_back(mk(1'b1, 1'b1, 5'd7,  2'b01, 3'b010, 2'd3, 32'h0, md, 32'h0, 1'b1, 32'h00000080));
        vecs.push_back(mk(1'b1, 1'b1, 5'd8,  2'b01, 3'b011, 2'd2, 32'h0, md, 32'h0, 1'b1, 32'hFFFF80FF));
        vecs.push_back(mk(1'b1, 1'b1, 5'd9,  2'b01, 3'b100, 2'd0, 32'h0, md, 32'h0, 1'b1, 32'h00007F01));
        vecs.push_back(mk(1'b1, 1'b1, 5'd10, 2'b01, 3'b000, 2'd2, 32'h0, md, 32'h0, 1'b1, 32'h80FF7F01));
        vecs.push_back(mk(1'b1, 1'b1, 5'd11, 2'b01, 3'b001, 2'd1, 32'h0, md, 32'h0, 1'b1, 32'h0000007F));
        vecs.push_back(mk(1'b1, 1'b1, 5'd12, 2'b01, 3'b010, 2'd2, 32'h0, md, 32'h0, 1'b1, 32'h000000FF));
        vecs.push_back(mk(1'b1, 1'b1, 5'd13, 2'b01, 3'b011, 2'd3, 32'h0, md, 32'h0, 1'b1, 32'hFFFF80FF));
        vecs.push_back(mk(1'b1, 1'b1, 5'd14, 2'b01, 3'b100, 2'd2, 32'h0, md, 32'h0, 1'b1, 32'h000080FF));
        vecs.push_back(mk(1'b1, 1'b1, 5'd15, 2'b01, 3'b111, 2'd1, 32'h0, md, 32'h0, 1'b1, 32'h80FF7F01));
        vecs.push_back(mk(1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 2'd0, 32'h000000AA, md, 32'h0, 1'b0, 32'h000000AA));
        vecs.push_back(mk(1'b1, 1'b1, 5'd31, 2'b10, 3'b000, 2'd0, 32'h11111111, md, 32'h00000040, 1'b1, 32'h00000040));
        vecs.push_back(mk(1'b1, 1'b0, 5'd3,  2'b11, 3'b000, 2'd0, 32'hDEADBEEF, md, 32'h00000040, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b1, 5'd7,  2'b00, 3'b000, 2'd0, 32'h00000055, md, 32'h0, 1'b0, 32'h00000055));
        vecs.push_back(mk(1'b1, 1'b1, 5'd4,  2'b00, 3'b000, 2'd0, 32'hCAFEF00D, md, 32'h0, 1'b1, 32'hCAFEF00D));

        foreach (vecs[i]) applyVec($sformatf("vec%0d", i), vecs[i]);

        // Stall three cycles with fresh inputs; outputs and counter must hold.
        for (int i = 0; i < 3; i++) begin
            t = mk(1'b1, 1'b1, 5'd20 + 5'(i), 2'b10, 3'b000, 2'd0, 32'h0, md, 32'h00000100 + 32'(i), 1'b1, 32'h00000100 + 32'(i));
            t.stall = 1'b1;
            applyVec($sformatf("stall%0d", i), t);
        end
        t = mk(1'b1, 1'b1, 5'd21, 2'b00, 3'b000, 2'd0, 32'h77777777, md, 32'h0, 1'b1, 32'h77777777);
        t.stall = 1'b1; t.flush = 1'b1;
        applyVec("stallflush", t);
        t = mk(1'b1, 1'b1, 5'd22, 2'b00, 3'b000, 2'd0, 32'h12345678, md, 32'h0, 1'b1, 32'h12345678);
        applyVec("resume", t);
        t.flush = 1'b1;
        applyVec("flush", t);
        t = mk(1'b1, 1'b1, 5'd23, 2'b00, 3'b000, 2'd0, 32'h0BADC0DE, md, 32'h0, 1'b1, 32'h0BADC0DE);
        applyVec("prereset", t);

        // Asynchronous reset between edges while Valid_o is high.
        #3;
        rst = 1'b1;
        #1;
        model = '{valid: 1'b0, regWrite: 1'b0, writeReg: 5'd0, writeData: 32'h0, count: 32'h0};
        expQ.push_back(model);
        compareOut("asyncreset");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4-bit counter wraps after 16 retirements.
        busS.Valid_i = 1'b1;
        busS.RegWrite_i = 1'b1;
        busS.WriteReg_i = 5'd1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("wrap count%0d", i), {28'd0, busS.RetireCount_o}, 32'((i + 1) % 16));
        end
        busS.Valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
